lfsr_rand_gen: RTL and testbench
================================

// Module: lfsr_rand_gen
// PURPOSE
//  Parametrised Galois-LFSR pseudo-random source with runtime seed load.
//  Mode 0 packs OUT_W successive LFSR bits into a word and offers it over a valid/ready port.
//  Mode 1 free-runs one bit per enabled cycle on bit_out.
//  Feeds game/test logic that needs random bits or words.
// PARAMETERS
//  WIDTH  32           LFSR state width, >=3
//  OUT_W  8            bits per output word, 1..WIDTH
//  TAPS   32'h80200003 Galois feedback mask (x^32+x^22+x^2+x+1); bit WIDTH-1 must be 1
//  SEED   32'h1E55B4E5 reset seed; also the substitute for any all-zero seed
// PORTS
//  clk        in  1      clock
//  rst        in  1      synchronous reset, active-high
//  en         in  1      advance enable; LFSR holds when low
//  mode       in  1      0=word mode, 1=serial free-run
//  seed_load  in  1      load seed_in on this edge
//  seed_in    in  WIDTH  new seed
//  rd_valid   out 1      word available (mode 0 only)
//  rd_ready   in  1      consumer accepts word
//  rd_data    out OUT_W  packed random word
//  bit_out    out 1      LFSR state[0] before the current step
//  seed_fix   out 1      pulse: all-zero seed replaced by SEED
// BEHAVIOUR
//  Reset (rst high at edge): state=SEED, FSM=FILL, cnt=0.
//   Outputs: rd_valid=0, rd_data=0, bit_out=0, seed_fix=0.
//   rst has priority over every other input.
//  Step (one LFSR advance):
//   out = state[0]
//   state <= (state>>1) ^ (out ? TAPS : 0)
//   bit_out <= out
//  FSM states: FILL, VALID.
//   FILL, mode=0, en=1: step.
//    Collected bit k (k=0 first) goes to rd_data[k].
//    cnt increments; cnt is $clog2(OUT_W+1) bits wide.
//    On the edge capturing bit OUT_W-1: rd_valid<=1, cnt<=0, go to VALID.
//    Latency: OUT_W enabled edges after the fill starts.
//   FILL, en=0: hold state, cnt and partial word.
//   VALID: LFSR frozen regardless of en, so the sequence is independent of backpressure.
//    rd_data is stable while rd_valid=1.
//    rd_valid&rd_ready at an edge: rd_valid<=0, go to FILL, cnt=0.
//    No prefetch; peak throughput is 1 word per OUT_W+1 cycles.
//  mode=1: FSM forced to FILL, cnt=0, rd_valid=0.
//   Step on every en cycle; bit_out updates per step.
//  mode change: takes effect on the next edge.
//   Partial or pending word is discarded (rd_valid<=0, cnt<=0).
//  seed_load (no rst):
//   state <= (seed_in==0) ? SEED : seed_in.
//   seed_fix<=1 for one cycle only if seed_in==0.
//   Pending or partial word discarded; FSM=FILL, cnt=0.
//   Overrides en, step and handshake on the same edge.
//   A simultaneous rd_valid&rd_ready is NOT a transfer.
//  Lock-up: state can never become 0.
//   Every load path passes through the zero-substitution.
//  Wrap: period is 2^WIDTH-1 for a primitive TAPS; no counter needed for wrap.
// STRUCTURE
//  rand_pkg: default TAPS constants for widths 4/8/16/32; FSM state typedef {FILL,VALID}.
//  Sub-module lfsr_step (combinational):
//   in: state, TAPS. out: next_state, out_bit.
//   Instantiated once.
//  Top: FSM, cnt, word shift register, seed/zero-substitution mux.
// TESTING (bench config WIDTH=4, TAPS=4'hC, SEED=4'h1, OUT_W=4 unless noted)
//  1 Serial: rst, mode=1, en=1 for 15 cycles -> bit_out = 1,0,0,1,1,0,1,0,1,1,1,1,0,0,0; state back to 1 after 15 steps.
//  2 Word: rst, mode=0, en=1, rd_ready=1.
//    -> rd_valid high after 4 edges with rd_data=4'h9.
//    -> next words 4'h5, then 4'hF, each after 5 cycles.
//  3 Backpressure: rd_ready=0 for 10 cycles after first valid.
//    -> rd_valid and rd_data=9 held; the following word is still 4'h5.
//  4 Zero seed: seed_load=1, seed_in=0 mid-fill.
//    -> seed_fix pulses once; state=1; rd_valid=0; sequence restarts as test 2.
//  5 Collision: seed_load=1, seed_in=4'h3, rd_valid&rd_ready on the same edge.
//    -> no transfer counted; next word = bits 1,1,0,1 = 4'hB.
//  6 Reset/mode mid-op: rst after 2 fill bits -> state=1, cnt=0.
//    Toggle mode 0->1 while rd_valid=1 -> rd_valid drops next edge.

Source files
------------

// File: rtl/lfsr_rand_gen_pkg.sv
// Shared constants and types for the LFSR random source: known-good Galois tap
// masks for common widths and the word-assembly FSM state type.
package lfsr_rand_gen_pkg;

    localparam logic [3:0]  TAPS_W4      = 4'hC;
    localparam logic [7:0]  TAPS_W8      = 8'hB8;
    localparam logic [15:0] TAPS_W16     = 16'hB400;
    localparam logic [31:0] TAPS_W32     = 32'h80200003;
    localparam logic [31:0] SEED_DEFAULT = 32'h1E55B4E5;

    typedef enum logic {
        FILL  = 1'b0,
        VALID = 1'b1
    } fsm_t;

    // Maximal-length mask for a supported width; zero flags an unsupported width.
    function automatic logic [31:0] default_taps(input int width);
        case (width)
            4:       return 32'(TAPS_W4);
            8:       return 32'(TAPS_W8);
            16:      return 32'(TAPS_W16);
            32:      return TAPS_W32;
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_rand_gen_step.sv
// One combinational Galois-LFSR advance: the bit shifted out of state[0]
// decides whether the tap mask is folded into the shifted state.
module lfsr_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] taps,
    output logic [WIDTH-1:0] next_state,
    output logic             out_bit
);

    assign out_bit    = state[0];
    assign next_state = (state >> 1) ^ (out_bit ? taps : '0);

endmodule

// File: rtl/lfsr_rand_gen.sv
// Galois-LFSR random source: packs OUT_W bits into a valid/ready word (mode 0)
// or free-runs one bit per enabled cycle on bit_out (mode 1), with seed reload.
module lfsr_rand_gen
    import lfsr_rand_gen_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter int               OUT_W = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W32),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(SEED_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [OUT_W-1:0] rd_data,
    output logic             bit_out,
    output logic             seed_fix
);

    localparam int               CNT_W    = $clog2(OUT_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

    fsm_t             fsm_reg;
    logic [WIDTH-1:0] lfsr_reg;
    logic [WIDTH-1:0] lfsr_next;
    logic             step_bit;
    logic [CNT_W-1:0] cnt_reg;
    logic [OUT_W-1:0] word_reg;
    logic [OUT_W-1:0] word_next;
    logic             valid_reg;
    logic             bit_out_reg;
    logic             seed_fix_reg;
    logic             seed_is_zero;
    logic [WIDTH-1:0] seed_sub;

    lfsr_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .state     (lfsr_reg),
        .taps      (TAPS),
        .next_state(lfsr_next),
        .out_bit   (step_bit)
    );

    // An all-zero seed would lock the LFSR, so it is replaced by SEED.
    assign seed_is_zero = (seed_in == '0);
    assign seed_sub     = seed_is_zero ? SEED : seed_in;

    // Collected bit k lands in word bit k; earlier bits are left untouched.
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_word
        assign word_next[gi] = (cnt_reg == CNT_W'(gi)) ? step_bit : word_reg[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_reg     <= SEED;
            fsm_reg      <= FILL;
            cnt_reg      <= '0;
            word_reg     <= '0;
            valid_reg    <= 1'b0;
            bit_out_reg  <= 1'b0;
            seed_fix_reg <= 1'b0;
        end else begin
            seed_fix_reg <= 1'b0;
            if (seed_load) begin
                // Reload wins over stepping and over a same-edge handshake.
                lfsr_reg     <= seed_sub;
                seed_fix_reg <= seed_is_zero;
                fsm_reg      <= FILL;
                cnt_reg      <= '0;
                valid_reg    <= 1'b0;
            end else if (mode) begin
                fsm_reg   <= FILL;
                cnt_reg   <= '0;
                valid_reg <= 1'b0;
                if (en) begin
                    lfsr_reg    <= lfsr_next;
                    bit_out_reg <= step_bit;
                end
            end else begin
                case (fsm_reg)
                    FILL: begin
                        if (en) begin
                            lfsr_reg    <= lfsr_next;
                            bit_out_reg <= step_bit;
                            word_reg    <= word_next;
                            if (cnt_reg == CNT_LAST) begin
                                cnt_reg   <= '0;
                                valid_reg <= 1'b1;
                                fsm_reg   <= VALID;
                            end else begin
                                cnt_reg <= cnt_reg + CNT_W'(1);
                            end
                        end
                    end
                    VALID: begin
                        // LFSR is frozen here so backpressure never alters the sequence.
                        if (rd_ready) begin
                            valid_reg <= 1'b0;
                            cnt_reg   <= '0;
                            fsm_reg   <= FILL;
                        end
                    end
                endcase
            end
        end
    end

    assign rd_valid = valid_reg;
    assign rd_data  = word_reg;
    assign bit_out  = bit_out_reg;
    assign seed_fix = seed_fix_reg;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Self-checking bench for lfsr_rand_gen (WIDTH=4, TAPS=4'hC, SEED=4'h1, OUT_W=4):
// expected words are queued as stimulus is driven and popped on each handshake.
module tb_lfsr_rand_gen;

    localparam int WIDTH = 4;
    localparam int OUT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             mode = 1'b0;
    logic             seed_load = 1'b0;
    logic [WIDTH-1:0] seed_in = '0;
    logic             rd_valid;
    logic             rd_ready = 1'b0;
    logic [OUT_W-1:0] rd_data;
    logic             bit_out;
    logic             seed_fix;

    int               tests_run = 0;
    int               tests_failed = 0;
    logic [OUT_W-1:0] sb_q[$];

    lfsr_rand_gen #(
        .WIDTH(WIDTH),
        .OUT_W(OUT_W),
        .TAPS (4'hC),
        .SEED (4'h1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .seed_load(seed_load),
        .seed_in  (seed_in),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .bit_out  (bit_out),
        .seed_fix (seed_fix)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        seed_load = 1'b0;
        rd_ready  = 1'b0;
        en        = 1'b0;
        mode      = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // Ticks at least once, then until rd_valid is seen; n is the edge count.
    task automatic wait_rise(output int n);
        n = 0;
        do begin
            tick;
            n++;
        end while (!rd_valid && n < 50);
    endtask

    // A word leaves the DUT on an edge with valid&ready and no reload/mode override.
    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready && !seed_load && !mode) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_word", 32'(sb_q.size()), 32'd1);
            end else begin
                check("sb_word", 32'(rd_data), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [14:0] ser_exp;
        ser_exp = 15'b000_1111_0101_1001;

        // Reset state, sampled while rst is still asserted.
        rst = 1'b1;
        tick;
        tick;
        check("rst_valid", 32'(rd_valid), 0);
        check("rst_data", 32'(rd_data), 0);
        check("rst_bit", 32'(bit_out), 0);
        check("rst_fix", 32'(seed_fix), 0);
        rst = 1'b0;

        // 1: serial free-run over a full period and into the next one.
        do_reset;
        mode = 1'b1;
        en   = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick;
            check($sformatf("ser_bit%0d", i), 32'(bit_out), 32'(ser_exp[i]));
        end
        check("ser_valid_low", 32'(rd_valid), 0);
        tick;
        check("ser_wrap0", 32'(bit_out), 1);
        tick;
        check("ser_wrap1", 32'(bit_out), 0);

        // 2: word stream with the consumer always ready.
        do_reset;
        sb_q.push_back(4'h9);
        sb_q.push_back(4'h5);
        sb_q.push_back(4'hF);
        en       = 1'b1;
        rd_ready = 1'b1;
        wait_rise(n);
        check("word_lat_first", 32'(n), 4);
        tick;
        wait_rise(n);
        check("word_gap2", 32'(n + 1), 5);
        tick;
        wait_rise(n);
        check("word_gap3", 32'(n + 1), 5);
        tick;
        rd_ready = 1'b0;
        check("word_drained", 32'(sb_q.size()), 0);

        // 3: backpressure holds the word and freezes the sequence.
        do_reset;
        sb_q.push_back(4'h9);
        sb_q.push_back(4'h5);
        en = 1'b1;
        wait_rise(n);
        check("bp_lat", 32'(n), 4);
        for (int i = 0; i < 10; i++) begin
            tick;
            if (i % 3 == 0) begin
                check($sformatf("bp_valid%0d", i), 32'(rd_valid), 1);
                check($sformatf("bp_data%0d", i), 32'(rd_data), 32'h9);
            end
        end
        rd_ready = 1'b1;
        tick;
        wait_rise(n);
        check("bp_next_lat", 32'(n), 4);
        tick;
        rd_ready = 1'b0;
        check("bp_drained", 32'(sb_q.size()), 0);

        // 4: zero seed mid-fill is substituted and restarts the sequence.
        do_reset;
        en       = 1'b1;
        rd_ready = 1'b1;
        tick;
        tick;
        seed_load = 1'b1;
        seed_in   = '0;
        tick;
        seed_load = 1'b0;
        check("zs_fix_pulse", 32'(seed_fix), 1);
        check("zs_valid_low", 32'(rd_valid), 0);
        sb_q.push_back(4'h9);
        sb_q.push_back(4'h5);
        wait_rise(n);
        check("zs_lat", 32'(n), 4);
        check("zs_fix_clear", 32'(seed_fix), 0);
        tick;
        wait_rise(n);
        tick;
        rd_ready = 1'b0;
        check("zs_drained", 32'(sb_q.size()), 0);

        // 5: reload colliding with a handshake is not a transfer.
        do_reset;
        en = 1'b1;
        wait_rise(n);
        check("col_lat", 32'(n), 4);
        rd_ready  = 1'b1;
        seed_load = 1'b1;
        seed_in   = 4'h3;
        tick;
        seed_load = 1'b0;
        check("col_valid_low", 32'(rd_valid), 0);
        check("col_no_fix", 32'(seed_fix), 0);
        sb_q.push_back(4'hB);
        wait_rise(n);
        check("col_lat2", 32'(n), 4);
        tick;
        rd_ready = 1'b0;
        check("col_drained", 32'(sb_q.size()), 0);

        // 6: reset mid-fill, then a mode switch while a word is pending.
        do_reset;
        en = 1'b1;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("mid_rst_valid", 32'(rd_valid), 0);
        check("mid_rst_bit", 32'(bit_out), 0);
        sb_q.push_back(4'h9);
        rd_ready = 1'b1;
        wait_rise(n);
        check("mid_rst_lat", 32'(n), 4);
        tick;
        rd_ready = 1'b0;
        wait_rise(n);
        check("mode_pend_lat", 32'(n), 4);
        check("mode_pend_data", 32'(rd_data), 32'h5);
        mode = 1'b1;
        tick;
        check("mode_valid_drop", 32'(rd_valid), 0);
        mode = 1'b0;
        tick;
        check("mode_drained", 32'(sb_q.size()), 0);

        // 7: en low during fill holds progress.
        do_reset;
        sb_q.push_back(4'h9);
        rd_ready = 1'b1;
        en       = 1'b1;
        tick;
        tick;
        en = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        check("hold_valid_low", 32'(rd_valid), 0);
        en = 1'b1;
        wait_rise(n);
        check("hold_lat", 32'(n), 2);
        tick;
        rd_ready = 1'b0;
        check("hold_drained", 32'(sb_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
